// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads instruction memory one word at a time
// over req/ack, and queues returned words with their PC for decode over valid/ready.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   input  logic        id_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

   typedef enum logic {
      S_FETCH,
      S_DROP
   } state_t;

   state_t           r_state;
   logic [31:0]      r_fetch_pc;
   logic             r_req;
   logic [31:0]      r_addr;
   logic [31:0]      r_buf_instr [BUF_DEPTH];
   logic [31:0]      r_buf_pc    [BUF_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic             w_ack;
   logic             w_waiting;
   logic             w_push;
   logic             w_pop;
   logic             w_valid;
   logic [31:0]      w_redirect_pc;
   logic [31:0]      w_fetch_pc_next;
   logic [CNT_W-1:0] w_count_next;
   state_t           w_state_next;
   logic             w_req_next;
   logic [31:0]      w_addr_next;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_ack         = r_req & imem_ack;
   assign w_waiting     = r_req & ~imem_ack;
   assign w_valid       = (r_count != '0);
   assign w_push        = (r_state == S_FETCH) & w_ack & ~redirect;
   assign w_pop         = w_valid & id_ready;
   assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

   always_comb begin
      w_fetch_pc_next = r_fetch_pc;
      if (redirect)
         w_fetch_pc_next = w_redirect_pc;
      else if (w_push)
         w_fetch_pc_next = r_fetch_pc + 32'd4;
   end

   always_comb begin
      w_count_next = r_count;
      if (redirect)
         w_count_next = '0;
      else if (w_push && !w_pop)
         w_count_next = r_count + CNT_W'(1);
      else if (!w_push && w_pop)
         w_count_next = r_count - CNT_W'(1);
   end

   // A redirect while a read is still in flight cannot cancel it; DROP swallows its data.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_FETCH: if (redirect && w_waiting) w_state_next = S_DROP;
         S_DROP:  if (w_ack) w_state_next = S_FETCH;
         default: w_state_next = S_FETCH;
      endcase
   end

   always_comb begin
      w_req_next  = 1'b1;
      w_addr_next = r_addr;
      if (!w_waiting) begin
         w_req_next  = (w_count_next < FULL_CNT);
         w_addr_next = w_fetch_pc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_FETCH;
         r_fetch_pc <= RESET_PC;
         r_req      <= 1'b0;
         r_addr     <= RESET_PC;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         r_state    <= w_state_next;
         r_fetch_pc <= w_fetch_pc_next;
         r_req      <= w_req_next;
         r_addr     <= w_addr_next;
         r_count    <= w_count_next;
         if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_buf_instr[r_wr_ptr] <= imem_rdata;
         r_buf_pc[r_wr_ptr]    <= r_fetch_pc;
      end
   end

   assign imem_req  = r_req;
   assign imem_addr = r_addr;
   assign id_valid  = w_valid;
   assign id_instr  = w_valid ? r_buf_instr[r_rd_ptr] : 32'h0;
   assign id_pc     = w_valid ? r_buf_pc[r_rd_ptr] : 32'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a transaction-level model of the decode stream
// feeds a scoreboard queue that a negedge monitor checks against the DUT.
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          BUF_DEPTH = 2;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        id_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   instr_fetch_unit #(
      .RESET_PC (RESET_PC),
      .BUF_DEPTH(BUF_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .id_valid   (id_valid),
      .id_instr   (id_instr),
      .id_pc      (id_pc),
      .id_ready   (id_ready),
      .redirect   (redirect),
      .redirect_pc(redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        sb_q[$];
   logic [31:0] exp_pc;
   bit          stale;
   bit          prev_rst_low;
   bit          prev_waiting;
   logic [31:0] prev_addr;
   int          n_checks;
   int          n_pass;
   int          n_pops;
   int          n_dropped;
   bit          mon_on;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: inputs and outputs are stable at negedge and describe the coming posedge.
   always @(negedge clk) begin
      if (mon_on) begin
         if (prev_rst_low) begin
            chk("reset_req",   {31'b0, imem_req}, 32'd0);
            chk("reset_valid", {31'b0, id_valid}, 32'd0);
            chk("reset_instr", id_instr, 32'd0);
            chk("reset_pc",    id_pc,    32'd0);
         end
         if (!rst) begin
            sb_q.delete();
            exp_pc       = RESET_PC;
            stale        = 1'b0;
            prev_rst_low = 1'b1;
            prev_waiting = 1'b0;
         end else begin
            if (prev_rst_low)
               chk("req_after_reset", {31'b0, imem_req}, 32'd0);
            else if (prev_waiting)
               chk("req_held", {31'b0, imem_req}, 32'd1);
            else
               chk("req_when_free", {31'b0, imem_req},
                   {31'b0, (sb_q.size() < BUF_DEPTH)});
            if (prev_waiting)
               chk("addr_held", imem_addr, prev_addr);
            chk("addr_aligned", {30'b0, imem_addr[1:0]}, 32'd0);
            chk("id_valid", {31'b0, id_valid}, {31'b0, (sb_q.size() != 0)});

            if (id_valid && id_ready) begin
               if (sb_q.size() == 0) begin
                  chk("pop_nonempty", 32'd0, 32'd1);
               end else begin
                  ent_t e;
                  e = sb_q.pop_front();
                  chk("id_pc",    id_pc,    e.pc);
                  chk("id_instr", id_instr, e.instr);
                  n_pops++;
               end
            end

            if (redirect) begin
               sb_q.delete();
               exp_pc = {redirect_pc[31:2], 2'b00};
            end

            if (imem_req && imem_ack) begin
               if (redirect || stale) begin
                  stale = 1'b0;
                  n_dropped++;
               end else begin
                  chk("fetch_addr", imem_addr, exp_pc);
                  sb_q.push_back({exp_pc, imem_rdata});
                  exp_pc = exp_pc + 32'd4;
               end
            end else if (imem_req && redirect) begin
               stale = 1'b1;
            end

            prev_waiting = imem_req && !imem_ack;
            prev_addr    = imem_addr;
            prev_rst_low = 1'b0;
         end
      end
   end

   task automatic drive(input logic r, input logic rdy, input logic rd,
                        input logic [31:0] rpc, input int ack_pct);
      @(posedge clk);
      #1;
      rst         = r;
      id_ready    = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      if (imem_req)
         imem_ack = ($urandom_range(99) < ack_pct);
      else
         imem_ack = ($urandom_range(99) < 15);
      imem_rdata = $urandom();
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      case ($urandom_range(3))
         0:       t = 32'hFFFF_FFF8 | 32'($urandom_range(7));
         1:       t = 32'h0000_0040 | 32'($urandom_range(3));
         default: t = $urandom();
      endcase
      return t;
   endfunction

   initial begin
      n_checks     = 0;
      n_pass       = 0;
      n_pops       = 0;
      n_dropped    = 0;
      stale        = 1'b0;
      prev_rst_low = 1'b0;
      prev_waiting = 1'b0;
      prev_addr    = '0;
      exp_pc       = RESET_PC;
      rst          = 1'b0;
      id_ready     = 1'b1;
      redirect     = 1'b0;
      redirect_pc  = '0;
      imem_ack     = 1'b0;
      imem_rdata   = '0;
      mon_on       = 1'b1;

      // reset, then zero-wait memory with decode always ready
      for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0, 32'h0, 100);
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 32'h0, 100);

      // decode backpressure then release
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 32'h0, 100);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 32'h0, 100);

      // redirect onto the top of the address space to exercise wrap
      drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 100);
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 32'h0, 100);

      // redirect while a slow read is in flight
      drive(1'b1, 1'b1, 1'b0, 32'h0, 0);
      drive(1'b1, 1'b1, 1'b1, 32'h0000_0100, 0);
      for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 1'b0, 32'h0, 0);
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 32'h0, 100);

      // randomized traffic with occasional redirects and mid-operation resets
      for (int i = 0; i < 4000; i++) begin
         logic r;
         logic rd;
         r  = ($urandom_range(199) != 0);
         rd = ($urandom_range(99) < 6);
         drive(r, ($urandom_range(99) < 70), rd, rand_target(),
               (i % 1000 < 500) ? 100 : 50);
      end

      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 32'h0, 100);
      @(posedge clk);
      #1;
      chk("decode_progress", {31'b0, (n_pops > 500)}, 32'd1);
      chk("stale_reads_seen", {31'b0, (n_dropped > 0)}, 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
